// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives a 4-bit falling-edge JK flop bank through LOAD/UP/DOWN/TOGGLE
// commands one step per cycle and flags a sticky error when the final bank value is wrong.
module jk_bank_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_arg,
    input  logic [3:0] q_fb,
    output logic [3:0] j,
    output logic [3:0] k,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, EXEC, CHECK} state_t;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_TGL  = 2'd3;
    state_t     r_state;
    logic [1:0] r_op;
    logic [3:0] r_arg;
    logic [3:0] r_exp;
    logic [3:0] r_cnt;
    logic       r_err;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic [3:0] w_exp;
    logic [3:0] w_cnt;
    logic [3:0] w_tgt;
    logic       w_exec;
    always_comb begin
        w_exp  = cmd_op == OP_LOAD ? cmd_arg :
                 cmd_op == OP_UP   ? q_fb + cmd_arg :
                 cmd_op == OP_DOWN ? q_fb - cmd_arg : q_fb ^ cmd_arg;
        w_cnt  = (cmd_op == OP_UP || cmd_op == OP_DOWN) ? cmd_arg : 4'd1;
        w_tgt  = r_op == OP_LOAD ? r_arg :
                 r_op == OP_UP   ? q_fb + 4'd1 : q_fb - 4'd1;
        w_exec = r_state == EXEC;
        // target-driven excitation never sets j and k together; only TOGGLE does
        j = !w_exec ? 4'b0000 : r_op == OP_TGL ? r_arg : w_tgt & ~q_fb;
        k = !w_exec ? 4'b0000 : r_op == OP_TGL ? r_arg : ~w_tgt & q_fb;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_LOAD;
            r_arg   <= 4'd0;
            r_exp   <= 4'd0;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_op    <= cmd_op;
                    r_arg   <= cmd_arg;
                    r_exp   <= w_exp;
                    r_cnt   <= w_cnt;
                    r_err   <= 1'b0;
                    r_state <= w_cnt != 4'd0 ? EXEC : CHECK;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_done  <= w_cnt == 4'd0;
                end
                EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= CHECK;
                        r_done  <= 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (q_fb != r_exp) r_err <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule
